// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    typedef logic [1:0] stop_bits_t;

    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide valid/ready in, asynchronous UART frame out on a registered txd pin.
// States: IDLE | waiting for a byte; START | start bit; DATA | 8 data bits LSB first;
//         PARITY | optional parity bit; STOP | 1 or 2 stop bits.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter stop_bits_t  STOP_BITS    = 2'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic STOP_LAST = (STOP_BITS == 2'd2);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        parity_q, parity_d;
    logic        stop_idx_q, stop_idx_d;
    logic        txd_q, txd_d;
    logic        alive_q;
    logic        bit_end, baud_clr, accept, last_stop;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (baud_clr),
        .bit_end(bit_end)
    );

    // alive_q keeps tx_ready low until the first clock after reset release
    assign last_stop  = (state_q == STOP) && bit_end && (stop_idx_q == STOP_LAST);
    assign tx_ready   = alive_q && ena && ((state_q == IDLE) || last_stop);
    assign accept     = tx_valid && tx_ready;
    assign baud_clr   = (state_q == IDLE) || accept;
    assign frame_done = last_stop;
    assign busy       = (state_q != IDLE);
    assign txd        = txd_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        stop_idx_d = stop_idx_q;
        txd_d      = txd_q;
        if (accept) begin
            state_d    = START;
            shift_d    = tx_data;
            parity_d   = calc_parity(tx_data, PARITY_ODD);
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
            txd_d      = 1'b0;
        end else if (bit_end) begin
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
                DATA: begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        // shift_q[0] always holds the bit currently on the line
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
                STOP: begin
                    if (last_stop) begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            parity_q   <= 1'b0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            parity_q   <= parity_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            alive_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench: three transmitter configurations compared against a bit-list frame model.
module tb_uart_byte_tx;
    import uart_pkg::*;

    localparam int CPB  = 4;
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] tx_data;
    logic       tx_valid   [NDUT];
    logic       tx_ready   [NDUT];
    logic       txd        [NDUT];
    logic       busy       [NDUT];
    logic       frame_done [NDUT];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // d0: no parity, 1 stop; d1: even parity, 2 stop; d2: odd parity, 1 stop
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2'd1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]), .frame_done(frame_done[0]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2'd2)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]), .frame_done(frame_done[1]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2'd1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]), .frame_done(frame_done[2]));

    function automatic int pe_of(input int s); return (s != 0) ? 1 : 0; endfunction
    function automatic int po_of(input int s); return (s == 2) ? 1 : 0; endfunction
    function automatic int sb_of(input int s); return (s == 1) ? 2 : 1; endfunction

    function automatic int frame_len(input int s);
        return (1 + 8 + pe_of(s) + sb_of(s)) * CPB;
    endfunction

    // Expected line level for bit slot idx of a frame carrying byte b
    function automatic logic exp_bit(input int s, input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (pe_of(s) == 1 && idx == 9) return (($countones(b) + po_of(s)) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int s, input logic [7:0] b);
        int w;
        tx_data     = b;
        tx_valid[s] = 1'b1;
        #1;
        w = 0;
        while (tx_ready[s] !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk($sformatf("ready_at_accept d%0d", s), 32'(tx_ready[s]), 32'd1);
        tick();
    endtask

    // Checks cycles 1..ncyc after the accept edge; ends at the sample point of cycle ncyc
    task automatic check_frame(input int s, input logic [7:0] b, input int ncyc, input int ena_drop_c,
                               input logic hold_valid, input logic nxt_valid, input logic [7:0] nxt_b);
        int len;
        len = frame_len(s);
        for (int c = 1; c <= ncyc; c++) begin
            if (c == ena_drop_c) ena = 1'b0;
            if (c == len) begin
                tx_valid[s] = nxt_valid;
                tx_data     = nxt_valid ? nxt_b : 8'($urandom);
            end else begin
                tx_valid[s] = hold_valid;
                tx_data     = 8'($urandom);
            end
            #1;
            chk($sformatf("txd d%0d b%02h c%0d", s, b, c), 32'(txd[s]), 32'(exp_bit(s, b, (c - 1) / CPB)));
            chk($sformatf("busy d%0d c%0d", s, c), 32'(busy[s]), 32'd1);
            chk($sformatf("frame_done d%0d c%0d", s, c), 32'(frame_done[s]), 32'(c == len));
            chk($sformatf("tx_ready d%0d c%0d", s, c), 32'(tx_ready[s]), (c == len) ? 32'(ena) : 32'd0);
            if (c < ncyc) tick();
        end
    endtask

    task automatic idle_check(input int s, input int n, input logic exp_ready);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("idle_txd d%0d", s), 32'(txd[s]), 32'd1);
            chk($sformatf("idle_busy d%0d", s), 32'(busy[s]), 32'd0);
            chk($sformatf("idle_done d%0d", s), 32'(frame_done[s]), 32'd0);
            chk($sformatf("idle_ready d%0d", s), 32'(tx_ready[s]), 32'(exp_ready));
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         rs;

        rst_n   = 1'b0;
        ena     = 1'b1;
        tx_data = 8'h00;
        for (int s = 0; s < NDUT; s++) tx_valid[s] = 1'b0;
        #12;
        for (int s = 0; s < NDUT; s++) begin
            chk($sformatf("rst_txd d%0d", s), 32'(txd[s]), 32'd1);
            chk($sformatf("rst_ready d%0d", s), 32'(tx_ready[s]), 32'd0);
            chk($sformatf("rst_busy d%0d", s), 32'(busy[s]), 32'd0);
            chk($sformatf("rst_done d%0d", s), 32'(frame_done[s]), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_clk", 32'(tx_ready[0]), 32'd0);
        tick();
        for (int s = 0; s < NDUT; s++)
            chk($sformatf("ready_after_rst d%0d", s), 32'(tx_ready[s]), 32'd1);

        // Single byte
        start_frame(0, 8'h41);
        check_frame(0, 8'h41, frame_len(0), 0, 1'b0, 1'b0, 8'h00);
        idle_check(0, 3, 1'b1);

        // Back-to-back with tx_valid held
        start_frame(0, 8'h53);
        check_frame(0, 8'h53, frame_len(0), 0, 1'b1, 1'b1, 8'h6F);
        tick();
        check_frame(0, 8'h6F, frame_len(0), 0, 1'b0, 1'b0, 8'h00);
        idle_check(0, 2, 1'b1);

        // Parity variants
        for (int s = 1; s < NDUT; s++) begin
            start_frame(s, 8'h41);
            check_frame(s, 8'h41, frame_len(s), 0, 1'b0, 1'b0, 8'h00);
            idle_check(s, 2, 1'b1);
        end

        // Random bytes across all configurations
        for (int i = 0; i < 8; i++) begin
            rs = int'($urandom_range(0, NDUT - 1));
            rb = 8'($urandom);
            start_frame(rs, rb);
            check_frame(rs, rb, frame_len(rs), 0, 1'b0, 1'b0, 8'h00);
            idle_check(rs, 1, 1'b1);
        end

        // Reset in the middle of a frame
        start_frame(0, 8'h7A);
        check_frame(0, 8'h7A, 17, 0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("midrst_txd", 32'(txd[0]), 32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_ready", 32'(tx_ready[0]), 32'd0);
        tick();
        chk("midrst_txd_held", 32'(txd[0]), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("postrst_ready_pre_clk", 32'(tx_ready[0]), 32'd0);
        tick();
        chk("postrst_ready", 32'(tx_ready[0]), 32'd1);
        chk("postrst_txd", 32'(txd[0]), 32'd1);
        chk("postrst_busy", 32'(busy[0]), 32'd0);
        start_frame(0, 8'h0A);
        check_frame(0, 8'h0A, frame_len(0), 0, 1'b0, 1'b0, 8'h00);
        idle_check(0, 2, 1'b1);

        // Disabled tile ignores a pending byte
        ena         = 1'b0;
        tx_valid[0] = 1'b1;
        tx_data     = 8'($urandom);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("dis_ready", 32'(tx_ready[0]), 32'd0);
            chk("dis_txd", 32'(txd[0]), 32'd1);
            chk("dis_busy", 32'(busy[0]), 32'd0);
        end

        // Enable drops mid-frame: frame completes, nothing further accepted
        ena = 1'b1;
        rb  = 8'($urandom);
        start_frame(0, rb);
        check_frame(0, rb, frame_len(0), 10, 1'b1, 1'b1, 8'($urandom));
        idle_check(0, 20, 1'b0);
        tx_valid[0] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
